// File: rtl/video_mode_sequencer_if.sv
// Control/status bundle between the mode sequencer and its surroundings:
// PLL lock, button, frame sync and auto enable in; pattern select, blanking
// and status out.
interface video_mode_sequencer_if #(
  parameter int C_switch_bits = 3
);
  logic                     locked;
  logic                     btn;
  logic                     vsync;
  logic                     auto_en;
  logic [C_switch_bits-1:0] switch;
  logic                     mute;
  logic                     ready;
  logic [7:0]               advance_cnt;

  // Board / generator side: drives the raw inputs, observes the outputs.
  modport master (
    output locked, btn, vsync, auto_en,
    input  switch, mute, ready, advance_cnt
  );

  // Sequencer side.
  modport slave (
    input  locked, btn, vsync, auto_en,
    output switch, mute, ready, advance_cnt
  );
endinterface

// File: rtl/video_mode_sequencer.sv
// Video mode sequencer: holds the HDMI path blanked until the PLL is locked
// and a few frames have settled, then steps the pattern select on a debounced
// button press or an auto-advance frame timer. Each step lands exactly on a
// frame boundary with blanking asserted before and held for a few frames after.
module video_mode_sequencer #(
  parameter int C_switch_bits    = 3,
  parameter int C_switch_init    = 4,
  parameter int C_debounce_bits  = 16,
  parameter int C_auto_frames    = 300,
  parameter int C_mute_frames    = 2,
  parameter int C_startup_frames = 4
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  video_mode_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_STARTUP,
    S_RUN,
    S_ARM,
    S_HOLD
  } state_t;

  // One frame counter serves both STARTUP and HOLD; it counts 0..N-1.
  localparam int C_frame_max = (C_startup_frames > C_mute_frames) ? C_startup_frames : C_mute_frames;
  localparam int C_frame_w   = (C_frame_max > 1) ? $clog2(C_frame_max) : 1;
  localparam int C_auto_w    = (C_auto_frames > 1) ? $clog2(C_auto_frames) : 1;

  localparam logic [C_debounce_bits-1:0] C_db_max       = '1;
  localparam logic [C_frame_w-1:0]       C_startup_last = C_frame_w'(C_startup_frames - 1);
  localparam logic [C_frame_w-1:0]       C_mute_last    = C_frame_w'(C_mute_frames - 1);
  localparam logic [C_auto_w-1:0]        C_auto_last    = C_auto_w'(C_auto_frames - 1);

  logic                       locked_meta_q, locked_sync_q;
  logic                       btn_meta_q, btn_sync_q;
  logic                       vsync_q;
  logic [C_debounce_bits-1:0] db_cnt_q, db_cnt_d;
  logic                       db_level_q, db_level_d;
  logic                       press_q, press_d;
  logic [C_auto_w-1:0]        auto_cnt_q, auto_cnt_d;
  logic [C_frame_w-1:0]       frame_cnt_q, frame_cnt_d;
  logic                       pending_q, pending_d;
  state_t                     state_q, state_d;
  logic [C_switch_bits-1:0]   switch_q, switch_d;
  logic [7:0]                 adv_q, adv_d;
  logic                       mute_q, mute_d;
  logic                       ready_q, ready_d;

  logic tick;
  logic auto_fire;
  logic request;
  logic apply;

  assign bus.switch      = switch_q;
  assign bus.mute        = mute_q;
  assign bus.ready       = ready_q;
  assign bus.advance_cnt = adv_q;

  // Frame boundary: first cycle of a vsync pulse.
  assign tick = bus.vsync & ~vsync_q;

  // Auto event on the C_auto_frames-th tick counted while running.
  assign auto_fire = (C_auto_frames > 0) && (state_q == S_RUN) && bus.auto_en
                     && tick && (auto_cnt_q == C_auto_last);

  // Press and auto in the same cycle merge into a single request.
  assign request = press_q | auto_fire;

  // Two-flop synchronizers for lock and button, plus the vsync delay for edge detect.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      vsync_q       <= 1'b0;
    end else begin
      locked_meta_q <= bus.locked;
      locked_sync_q <= locked_meta_q;
      btn_meta_q    <= bus.btn;
      btn_sync_q    <= btn_meta_q;
      vsync_q       <= bus.vsync;
    end
  end

  // Debouncer: count cycles the button disagrees with the debounced level;
  // agreement restarts the count. A rising debounced level yields a press.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (btn_sync_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == C_db_max) begin
      db_level_d = btn_sync_q;
      db_cnt_d   = '0;
      press_d    = btn_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Mode FSM next-state, frame/auto timers, pending request and pattern update.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    switch_d    = switch_q;
    adv_d       = adv_q;
    auto_cnt_d  = auto_cnt_q;
    apply       = 1'b0;

    if (!locked_sync_q) begin
      // Lock loss aborts whatever was in progress; the pattern is kept.
      state_d     = S_WAIT_LOCK;
      frame_cnt_d = '0;
      pending_d   = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          state_d     = S_STARTUP;
          frame_cnt_d = '0;
        end
        S_STARTUP: begin
          if (C_startup_frames == 0) begin
            state_d = S_RUN;
          end else if (tick) begin
            if (frame_cnt_q == C_startup_last) begin
              state_d     = S_RUN;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (request || pending_q) begin
            state_d   = S_ARM;
            pending_d = 1'b0;
          end
        end
        S_ARM: begin
          if (request) pending_d = 1'b1;
          if (tick) begin
            apply       = 1'b1;
            switch_d    = switch_q + 1'b1;
            adv_d       = adv_q + 8'd1;
            frame_cnt_d = '0;
            state_d     = (C_mute_frames == 0) ? S_RUN : S_HOLD;
          end
        end
        S_HOLD: begin
          if (request) pending_d = 1'b1;
          if (tick) begin
            if (frame_cnt_q == C_mute_last) begin
              state_d     = S_RUN;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_WAIT_LOCK;
      endcase
    end

    // Auto timer only advances on ticks spent in RUN with auto enabled.
    if (!locked_sync_q || !bus.auto_en || apply) begin
      auto_cnt_d = '0;
    end else if ((C_auto_frames > 0) && (state_q == S_RUN) && tick) begin
      auto_cnt_d = auto_fire ? '0 : auto_cnt_q + 1'b1;
    end

    // Outputs follow the next state so they are registered alongside it.
    mute_d  = (state_d != S_RUN);
    ready_d = (state_d == S_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      press_q     <= 1'b0;
      auto_cnt_q  <= '0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      state_q     <= S_WAIT_LOCK;
      switch_q    <= C_switch_bits'(C_switch_init);
      adv_q       <= '0;
      mute_q      <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      press_q     <= press_d;
      auto_cnt_q  <= auto_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      switch_q    <= switch_d;
      adv_q       <= adv_d;
      mute_q      <= mute_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: directed scenarios with
// randomized button/lock timing followed by a random soak, all compared
// every cycle against a behavioural model of the mode rules.
module tb_video_mode_sequencer;

  localparam int STARTUP_FRAMES = 4;
  localparam int MUTE_FRAMES    = 2;
  localparam int AUTO_FRAMES    = 3;
  localparam int DEBOUNCE_LEN   = 16;
  localparam int SWITCH_INIT    = 4;

  localparam int PH_WAIT  = 0;
  localparam int PH_START = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_ARM   = 3;
  localparam int PH_HOLD  = 4;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b1;

  video_mode_sequencer_if #(.C_switch_bits(3)) vif ();

  video_mode_sequencer #(
    .C_switch_bits   (3),
    .C_switch_init   (SWITCH_INIT),
    .C_debounce_bits (4),
    .C_auto_frames   (AUTO_FRAMES),
    .C_mute_frames   (MUTE_FRAMES),
    .C_startup_frames(STARTUP_FRAMES)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .bus      (vif)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model state
  int m_phase, m_sw, m_adv, m_pending, m_frames, m_auto_ticks;
  int m_lk_meta, m_lk_sync, m_bt_meta, m_bt_sync, m_vs_prev;
  int m_run_len, m_bt_last, m_level, m_press;

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      if (n_fail >= 50) finish_test();
    end
  endtask

  task automatic model_reset();
    m_phase = PH_WAIT; m_sw = SWITCH_INIT; m_adv = 0; m_pending = 0;
    m_frames = 0; m_auto_ticks = 0;
    m_lk_meta = 0; m_lk_sync = 0; m_bt_meta = 0; m_bt_sync = 0; m_vs_prev = 0;
    m_run_len = 0; m_bt_last = 0; m_level = 0; m_press = 0;
  endtask

  // Advance the model by one clock given the inputs applied for that clock.
  task automatic model_step(input int vs, input int lk, input int bt, input int ae);
    int tick, auto_ev, req, applied, prev_phase, new_press;
    tick       = (vs != 0 && m_vs_prev == 0) ? 1 : 0;
    prev_phase = m_phase;
    auto_ev    = (prev_phase == PH_RUN && ae != 0 && tick != 0 &&
                  m_auto_ticks + 1 == AUTO_FRAMES) ? 1 : 0;
    req        = (m_press != 0 || auto_ev != 0) ? 1 : 0;
    applied    = 0;

    if (m_lk_sync == 0) begin
      m_phase = PH_WAIT; m_pending = 0; m_frames = 0;
    end else begin
      case (prev_phase)
        PH_WAIT: begin m_phase = PH_START; m_frames = 0; end
        PH_START: if (tick != 0) begin
          m_frames++;
          if (m_frames == STARTUP_FRAMES) begin m_phase = PH_RUN; m_frames = 0; end
        end
        PH_RUN: if (req != 0 || m_pending != 0) begin m_phase = PH_ARM; m_pending = 0; end
        PH_ARM: begin
          if (req != 0) m_pending = 1;
          if (tick != 0) begin
            m_sw = (m_sw + 1) % 8; m_adv = (m_adv + 1) % 256;
            applied = 1; m_phase = PH_HOLD; m_frames = 0;
          end
        end
        PH_HOLD: begin
          if (req != 0) m_pending = 1;
          if (tick != 0) begin
            m_frames++;
            if (m_frames == MUTE_FRAMES) begin m_phase = PH_RUN; m_frames = 0; end
          end
        end
        default: m_phase = PH_WAIT;
      endcase
    end

    if (m_lk_sync == 0 || ae == 0 || applied != 0) m_auto_ticks = 0;
    else if (prev_phase == PH_RUN && tick != 0) m_auto_ticks = (auto_ev != 0) ? 0 : m_auto_ticks + 1;

    // Debounce: the level follows a synchronized value held for DEBOUNCE_LEN cycles.
    if (m_bt_sync == m_bt_last) begin
      if (m_run_len < 1000) m_run_len++;
    end else begin
      m_run_len = 1;
    end
    m_bt_last = m_bt_sync;
    new_press = 0;
    if (m_run_len >= DEBOUNCE_LEN && m_bt_sync != m_level) begin
      m_level   = m_bt_sync;
      new_press = m_bt_sync;
    end
    m_press = new_press;

    m_lk_sync = m_lk_meta; m_lk_meta = lk;
    m_bt_sync = m_bt_meta; m_bt_meta = bt;
    m_vs_prev = vs;
  endtask

  // One clock: drive vsync, predict, clock, compare all outputs.
  task automatic cycle();
    int vs;
    vs = ((cyc % 100) >= 50 && (cyc % 100) < 53) ? 1 : 0;
    vif.vsync = vs[0];
    model_step(vs, int'(vif.locked), int'(vif.btn), int'(vif.auto_en));
    @(posedge clk_pixel);
    #1;
    cyc++;
    check_eq("switch",      32'(vif.switch),      32'(m_sw));
    check_eq("advance_cnt", 32'(vif.advance_cnt), 32'(m_adv));
    check_eq("mute",        32'(vif.mute),        (m_phase != PH_RUN) ? 32'd1 : 32'd0);
    check_eq("ready",       32'(vif.ready),       (m_phase == PH_RUN) ? 32'd1 : 32'd0);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag);
    int waited;
    waited = 0;
    while (m_phase != p && waited < budget) begin
      cycle();
      waited++;
    end
    if (m_phase != p) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic press(input int hi, input int lo);
    vif.btn = 1'b1;
    run_cycles(hi);
    vif.btn = 1'b0;
    run_cycles(lo);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_switch"}, 32'(vif.switch),      32'(SWITCH_INIT));
    check_eq({tag, "_adv"},    32'(vif.advance_cnt), 32'd0);
    check_eq({tag, "_mute"},   32'(vif.mute),        32'd1);
    check_eq({tag, "_ready"},  32'(vif.ready),       32'd0);
  endtask

  initial begin
    #3_000_000;
    check_eq("watchdog", 32'd0, 32'd1);
    finish_test();
  end

  initial begin
    int sw_pre, adv_pre, n;
    vif.locked = 1'b0; vif.btn = 1'b0; vif.vsync = 1'b0; vif.auto_en = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_pixel);
    #1 reset_n = 1'b1;

    // 1: no lock -> stays blanked; lock -> startup frames then RUN
    run_cycles(300);
    check_eq("s1_unlocked_ready", 32'(vif.ready), 32'd0);
    vif.locked = 1'b1;
    wait_phase(PH_RUN, 700, "s1_run_timeout");
    check_eq("s1_ready", 32'(vif.ready), 32'd1);
    check_eq("s1_mute",  32'(vif.mute),  32'd0);

    // 2: manual press advances 4 -> 5
    press($urandom_range(20, 30), 10);
    wait_phase(PH_ARM, 200, "s2_arm_timeout");
    wait_phase(PH_HOLD, 200, "s2_hold_timeout");
    wait_phase(PH_RUN, 400, "s2_run_timeout");
    check_eq("s2_switch", 32'(vif.switch),      32'd5);
    check_eq("s2_adv",    32'(vif.advance_cnt), 32'd1);

    // 3: short glitches never register
    repeat (12) begin
      vif.btn = 1'b1;
      run_cycles($urandom_range(1, 14));
      vif.btn = 1'b0;
      run_cycles($urandom_range(2, 10));
    end
    run_cycles(30);
    check_eq("s3_switch", 32'(vif.switch), 32'd5);
    check_eq("s3_mute",   32'(vif.mute),   32'd0);

    // 4: auto-advance up to 7, wrap to 0, two presses in HOLD give one more step
    vif.auto_en = 1'b1;
    n = 0;
    while (!(m_sw == 7 && m_phase == PH_RUN) && n < 3000) begin cycle(); n++; end
    check_eq("s4_reach7", 32'(m_sw), 32'd7);
    adv_pre = m_adv;
    wait_phase(PH_HOLD, 600, "s4_wrap_timeout");
    check_eq("s4_wrap", 32'(vif.switch), 32'd0);
    vif.auto_en = 1'b0;
    press(20, 20);
    press(20, 10);
    wait_phase(PH_ARM, 400, "s4_pend_arm_timeout");
    wait_phase(PH_HOLD, 200, "s4_pend_hold_timeout");
    wait_phase(PH_RUN, 400, "s4_pend_run_timeout");
    run_cycles(400);
    check_eq("s4_adv_plus2", 32'(vif.advance_cnt), 32'((adv_pre + 2) % 256));
    check_eq("s4_switch",    32'(vif.switch),      32'd1);

    // 5: lock lost during ARM aborts the update; relock restarts startup
    n = 0;
    while ((cyc % 100) != 55 && n < 200) begin cycle(); n++; end
    sw_pre = m_sw; adv_pre = m_adv;
    press(20, 0);
    wait_phase(PH_ARM, 50, "s5_arm_timeout");
    vif.locked = 1'b0;
    wait_phase(PH_WAIT, 10, "s5_wait_timeout");
    check_eq("s5_mute",   32'(vif.mute),   32'd1);
    check_eq("s5_ready",  32'(vif.ready),  32'd0);
    check_eq("s5_switch", 32'(vif.switch), 32'(sw_pre));
    run_cycles($urandom_range(20, 200));
    vif.locked = 1'b1;
    wait_phase(PH_RUN, 700, "s5_relock_timeout");
    run_cycles(300);
    check_eq("s5_no_stale_switch", 32'(vif.switch),      32'(sw_pre));
    check_eq("s5_no_stale_adv",    32'(vif.advance_cnt), 32'(adv_pre));

    // 6: asynchronous reset in the middle of HOLD
    press(20, 5);
    wait_phase(PH_HOLD, 300, "s6_hold_timeout");
    n = $urandom_range(1, 120);
    while (m_phase == PH_HOLD && n > 0) begin cycle(); n--; end
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("s6_async");
    model_reset();
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #1 check_reset_outputs("s6_held");
    reset_n = 1'b1;
    wait_phase(PH_RUN, 800, "s6_run_timeout");

    // Random soak: button, lock and auto enable all wander
    repeat (120) begin
      vif.btn     = 1'($urandom_range(0, 1));
      vif.auto_en = ($urandom_range(0, 3) != 0);
      vif.locked  = ($urandom_range(0, 9) != 0);
      run_cycles($urandom_range(1, 60));
    end
    vif.locked = 1'b1;
    vif.btn    = 1'b0;
    run_cycles(1200);

    finish_test();
  end

endmodule

// File: doc/video_mode_sequencer.md
Name: video_mode_sequencer

Overview:
Controller that configures and sequences the caleidoscope pattern generator and its VGA-to-HDMI output path. It gates video output until the PLL has locked and a startup settle period has elapsed. It then changes the generator SWITCH pattern, either on a debounced button press or on an auto-advance frame timer. Every change is applied only at a frame boundary, with blanking forced around the change so the display never shows a partial frame.

Parameters:
C_switch_bits, 3, width of the pattern select output
C_switch_init, 4, pattern value loaded at reset (3'b100)
C_debounce_bits, 16, button must be stable for 2^C_debounce_bits consecutive clk_pixel cycles
C_auto_frames, 300, frames between automatic advances in RUN; 0 disables auto-advance
C_mute_frames, 2, frame ticks that mute stays asserted after a pattern update
C_startup_frames, 4, frame ticks that mute stays asserted after lock before entering RUN

Ports:
clk_pixel  in  1  pixel clock; all logic runs in this single domain
reset_n  in  1  asynchronous active-low reset
locked  in  1  PLL lock, asynchronous; 2-FF synchronized internally
btn  in  1  raw button, active-high, asynchronous; 2-FF synchronized internally
vsync  in  1  generator vsync, clk_pixel synchronous, active-high
auto_en  in  1  level; enables the auto-advance timer
switch  out  C_switch_bits  pattern select to the generator
mute  out  1  forces blank on the HDMI path when 1
ready  out  1  1 only in the RUN state
advance_cnt  out  8  count of applied pattern changes; wraps 255->0

Behaviour:
- Reset (reset_n=0, async): switch=C_switch_init, mute=1, ready=0, advance_cnt=0, state=WAIT_LOCK. Synchronizers, debouncer, timers and the pending flag are cleared.
- Frame tick: vsync_q registers vsync. tick = vsync & ~vsync_q, asserted in the first cycle vsync is high.
- Debounce: the synchronized btn feeds a counter that restarts on any change. The debounced level updates when the counter reaches 2^C_debounce_bits-1. A press event is a 1-cycle pulse on a debounced 0->1 edge. Release generates no event.
- Auto timer: counts ticks only in RUN with auto_en=1. At C_auto_frames it fires an auto event and clears. It clears on any applied advance and whenever auto_en=0. With C_auto_frames=0 it never fires.
- Request = press event OR auto event. Simultaneous press and auto in the same cycle count as one request.
- States:
  - WAIT_LOCK: mute=1, ready=0. Goes to STARTUP when locked_sync=1.
  - STARTUP: mute=1. Counts ticks; after the C_startup_frames-th tick, goes to RUN on the next cycle. With C_startup_frames=0, goes to RUN the cycle after entry.
  - RUN: mute=0, ready=1. A request, or a set pending flag, goes to ARM; mute rises on the cycle after the request.
  - ARM: mute=1. Waits for a tick. On that tick: switch <= switch+1 (modulo 2^C_switch_bits, so all-ones wraps to 0), advance_cnt += 1, then go to HOLD.
  - HOLD: mute=1. Counts C_mute_frames ticks, the apply tick excluded. Returns to RUN the cycle after the last one. With C_mute_frames=0, returns to RUN the cycle after apply.
- Requests arriving in ARM or HOLD set a single pending flag; further requests are dropped. The pending flag is consumed when RUN transitions to ARM. Requests in WAIT_LOCK or STARTUP are discarded.
- locked_sync=0 in any state: next cycle state=WAIT_LOCK, mute=1, ready=0. The pending flag and timers clear; switch and advance_cnt keep their values. A lock loss during ARM means no update is applied.
- Exactly one switch update per ARM visit. switch never changes while mute=0.
- No outputs are combinational from inputs; all are registered.

Test Plan:
All scenarios use C_debounce_bits=4, C_auto_frames=3, C_mute_frames=2, C_startup_frames=4, with vsync pulsing every 100 cycles.
1. Reset, locked=0 -> switch=4, mute=1, ready=0 indefinitely. locked=1 -> ready=1 and mute=0 one cycle after the 4th tick following lock sync.
2. In RUN, auto_en=0, btn high for 20 cycles -> mute=1; switch 4->5 on the next tick; advance_cnt=1; mute=0 one cycle after 2 further ticks.
3. btn glitches shorter than 16 cycles, repeated -> no request; switch stays 5 and mute stays 0.
4. auto_en=1, switch=7 -> after 3 ticks switch wraps 7->0. Two presses during HOLD -> exactly one extra advance follows; advance_cnt increments by 2 in total.
5. locked dropped during ARM -> mute=1 and ready=0 with switch unchanged. Relock -> the 4-tick startup repeats and no stale advance occurs.
6. reset_n asserted mid-HOLD, asynchronously -> switch=4, advance_cnt=0, mute=1 immediately without waiting for a clock edge.
